// File: rtl/cmm_errman_cor_cnt.sv
// Correctable-error outstanding counter with ERR_COR request/grant handshake.
// Accumulates upstream deltas into a saturating count; each grant returns one decr_cor pulse.
module cmm_errman_cor_cnt #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cor_num,
  input  logic             inc_dec_b,
  input  logic             reg_decr_cor,
  input  logic             cor_ack,
  output logic             cor_req,
  output logic             decr_cor,
  output logic [CNT_W-1:0] cor_cnt,
  output logic             cor_sat
);

  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam int unsigned WAIT_W = 3;

  localparam logic signed [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DEC  = 2'd2,
    WAIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               req_q, req_d;
  logic               dec_q, dec_d;

  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] sum;

  // Signed delta and clamped count update
  always_comb begin
    delta = '0;
    sum   = '0;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (inc_dec_b) begin
      delta = $signed(SUM_W'(cor_num)) - $signed(SUM_W'(reg_decr_cor));
    end else begin
      delta = -$signed(SUM_W'(cor_num));
    end
    sum = $signed({2'b00, cnt_q}) + delta;
    if (sum < 0) begin
      cnt_d = '0;
    end else if (sum > CNT_MAX) begin
      cnt_d = {CNT_W{1'b1}};
      sat_d = 1'b1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  // Request/grant sequencing; WAIT covers the upstream echo latency
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = 1'b0;
    dec_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (cor_ack) begin
          state_d = DEC;
          dec_d   = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      DEC: begin
        state_d = WAIT;
        wait_d  = WAIT_W'(DEC_LAT);
      end
      WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      req_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      req_q   <= req_d;
      dec_q   <= dec_d;
    end
  end

  assign cor_req  = req_q;
  assign decr_cor = dec_q;
  assign cor_cnt  = cnt_q;
  assign cor_sat  = sat_q;

endmodule
